// File: rtl/tpu_host_sequencer.sv
// Host-side initiator for the TPU byte/mode protocol: loads a 2x2 int8 pair,
// runs the compute phase, reads back four result bytes and pulses done.
module tpu_host_sequencer #(
  parameter int unsigned COMPUTE_CYCLES = 10,
  parameter int unsigned READ_LAT       = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] mat_a,
  input  logic [31:0] mat_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [7:0]  tpu_data,
  output logic [7:0]  tpu_ctrl,
  input  logic [7:0]  tpu_out
);

  // state | meaning: IDLE wait | LOAD_A/LOAD_B shift operands | COMPUTE run | READ capture | DONE pulse
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, COMPUTE, READ, DONE} state_t;

  localparam logic [1:0] MODE_A    = 2'b00;
  localparam logic [1:0] MODE_B    = 2'b01;
  localparam logic [1:0] MODE_CALC = 2'b10;
  localparam logic [1:0] MODE_READ = 2'b11;

  localparam logic [7:0] CALC_LAST  = 8'(COMPUTE_CYCLES - 1);
  localparam logic [7:0] READ_FIRST = 8'(READ_LAT);
  localparam logic [7:0] READ_LAST  = 8'(READ_LAT + 3);

  state_t      state;
  logic [7:0]  cnt;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [1:0]  mode;
  logic [7:0]  rd_idx;
  logic [1:0]  nxt_sel;

  assign tpu_ctrl = {6'b0, mode};
  assign rd_idx   = cnt - READ_FIRST;
  // operands go out most-significant byte first: byte 3 - (cnt + 1)
  assign nxt_sel  = ~(cnt[1:0] + 2'd1);

  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] idx);
    return w[{idx, 3'b000} +: 8];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      mode     <= MODE_A;
      tpu_data <= 8'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          mode     <= MODE_A;
          tpu_data <= 8'd0;
          done     <= 1'b0;
          if (start) begin
            a_q      <= mat_a;
            b_q      <= mat_b;
            busy     <= 1'b1;
            cnt      <= 8'd0;
            state    <= LOAD_A;
            tpu_data <= mat_a[31:24];
          end
        end
        LOAD_A: begin
          if (cnt == 8'd3) begin
            state    <= LOAD_B;
            cnt      <= 8'd0;
            mode     <= MODE_B;
            tpu_data <= b_q[31:24];
          end else begin
            cnt      <= cnt + 8'd1;
            tpu_data <= byte_of(a_q, nxt_sel);
          end
        end
        LOAD_B: begin
          if (cnt == 8'd3) begin
            state    <= COMPUTE;
            cnt      <= 8'd0;
            mode     <= MODE_CALC;
            tpu_data <= 8'd0;
          end else begin
            cnt      <= cnt + 8'd1;
            tpu_data <= byte_of(b_q, nxt_sel);
          end
        end
        COMPUTE: begin
          if (cnt == CALC_LAST) begin
            state <= READ;
            cnt   <= 8'd0;
            mode  <= MODE_READ;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        READ: begin
          if (cnt >= READ_FIRST) begin
            result[{rd_idx[1:0], 3'b000} +: 8] <= tpu_out;
          end
          if (cnt == READ_LAST) begin
            state <= DONE;
            cnt   <= 8'd0;
            mode  <= MODE_A;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          cnt   <= 8'd0;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          cnt   <= 8'd0;
          mode  <= MODE_A;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/tpu_host_sequencer.md
Name: tpu_host_sequencer

Overview:
- Host-side initiator for the TPU byte/mode protocol. It drives the TPU's data input and mode control, and samples the TPU's output bus.
- Accepts one 2x2 int8 matrix pair as a parallel command, then sequences LOAD A, LOAD B, COMPUTE and READ.
- Collects the 4 result bytes into a parallel word and pulses done.
- Sits in the harness or SoC wrapper between a parallel command source and the TPU pins.

Parameters:
- COMPUTE_CYCLES, 10: cycles spent in mode 10. Legal range 8..255; covers the counter reset plus array drain.
- READ_LAT, 1: cycles from entering mode 11 to the first valid tpu_out byte. Legal range 0..3.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  command request; accepted only in IDLE
- mat_a  in  32  [7:0]=A00, [15:8]=A01, [23:16]=A10, [31:24]=A11
- mat_b  in  32  same packing as mat_a, for B
- busy  out  1  high from acceptance through the DONE cycle
- done  out  1  one-cycle pulse; result is valid
- result  out  32  captured bytes; first captured byte in [7:0]
- tpu_data  out  8  to TPU data input (ui_in)
- tpu_ctrl  out  8  to TPU control input (uio_in); [1:0]=mode, [7:2]=0
- tpu_out  in  8  from TPU data output (uo_out)

Behaviour:
- Reset: one clock, asynchronous active-low reset rst_n. Reset forces state=IDLE, busy=0, done=0, result=0, tpu_data=0, tpu_ctrl=0.
- States: IDLE, LOAD_A, LOAD_B, COMPUTE, READ, DONE. One shared 8-bit cycle counter, cleared on every state entry.
- IDLE:
  - Drives mode 00 with data 0. This shifts zeros into the TPU's A register and holds the array cleared; both are harmless.
  - When start is sampled high at a clock edge, latch mat_a/mat_b, set busy, and go to LOAD_A.
- LOAD_A (4 cycles):
  - mode 00. tpu_data = A11, A10, A01, A00 in cycles 0..3. The TPU shift chain then holds A[0]=A00 ... A[3]=A11.
  - Go to LOAD_B after cycle 3.
- LOAD_B (4 cycles): mode 01. tpu_data = B11, B10, B01, B00. Go to COMPUTE after cycle 3.
- COMPUTE (COMPUTE_CYCLES cycles): mode 10, tpu_data=0. Go to READ after the last cycle.
- READ (READ_LAT+4 cycles):
  - mode 11, tpu_data=0.
  - At READ cycle READ_LAT+k (k=0..3), sample tpu_out at the end of that cycle into result[8k+7:8k].
  - Go to DONE after the last cycle.
- DONE (1 cycle): done=1, busy=1, mode 00, data 0. Then return to IDLE.
- Timing: with acceptance at edge 0, LOAD_A occupies cycles 1..4. done is high in cycle 9+COMPUTE_CYCLES+READ_LAT+4, which is cycle 24 with the defaults.
- Outputs tpu_data and tpu_ctrl are registered. The mode never changes mid-phase, and each phase holds its mode for exactly its stated length.
- start while busy is ignored. Latched operands are not affected by mat_a/mat_b changing after acceptance.
- start high in the DONE cycle is ignored. start high in the following IDLE cycle is accepted, so back-to-back commands have a 1-cycle IDLE gap.
- result holds its value from the DONE cycle until the next capture overwrites each byte. It is not cleared on start.
- Reset asserted mid-operation: immediate return to the reset values, no done pulse. A partial result is discarded and zeroed.
- No arithmetic is performed. Bytes pass unmodified.

Test Plan:
- Reset/idle: hold rst_n=0 while start=1 and tpu_out=FF. Required: all outputs 0. Release rst_n with start=0 and hold 5 cycles: tpu_ctrl=00, tpu_data=00, busy=0.
- Load sequencing: mat_a=32'h04030201, mat_b=32'h08070605, pulse start. Required:
  - cycles 1..4: tpu_ctrl=00, tpu_data=04,03,02,01
  - cycles 5..8: tpu_ctrl=01, tpu_data=08,07,06,05
  - cycles 9..18: tpu_ctrl=02
  - cycles 19..23: tpu_ctrl=03
- Capture: stub drives tpu_out=11,22,33,44 in READ cycles 1..4. Required: result=32'h44332211 and done high exactly in cycle 24 only.
- End-to-end with a tpu_top model: A=[[1,2],[3,4]], B=[[5,6],[7,8]]. Required: result bytes are {19,22,43,50} in the model's chain order. Repeat with A=identity: result equals B in that same order.
- Protocol corner: start pulsed again in cycles 3 and 24. Required: both ignored. start held continuously: next command begins LOAD_A in cycle 26, and mat_b changed at cycle 2 has no effect on the first command.
- Reset mid-op: assert rst_n=0 in COMPUTE cycle 4. Required: immediate zero outputs, no done. A fresh command afterwards completes with correct result.
